// File: rtl/cc_frame_sched_if.sv
// Pixel-in / block-out stream bundle for the 2x2 colorspace frame scheduler.
// Ports: pix_valid/pix_ready/pix_data (RGB in), blk_valid/blk_ready/blk_y/blk_c (block out).
interface cc_frame_sched_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_y;
    logic [15:0] blk_c;

    modport master (
        output pix_valid, pix_data, blk_ready,
        input  pix_ready, blk_valid, blk_y, blk_c
    );

    modport slave (
        input  pix_valid, pix_data, blk_ready,
        output pix_ready, blk_valid, blk_y, blk_c
    );
endinterface

// File: rtl/cc_frame_sched.sv
// Frame scheduler: buffers an even line, feeds each 2x2 block to the converter,
// waits its latency and emits Y/C as one block.
// Ports: clk, rst_n, start/width/height (config), busy/done/err (status),
//        bus (pixel in + block out streams), conv_rgb_* out, conv_y/conv_c in.
module cc_frame_sched #(
    parameter int MAX_WIDTH = 640,
    parameter int DIM_BITS  = 10,
    parameter int CONV_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DIM_BITS-1:0] width,
    input  logic [DIM_BITS-1:0] height,
    output logic                busy,
    output logic                done,
    output logic                err,
    cc_frame_sched_if.slave     bus,
    output logic [23:0]         conv_rgb_ul,
    output logic [23:0]         conv_rgb_ur,
    output logic [23:0]         conv_rgb_dl,
    output logic [23:0]         conv_rgb_dr,
    input  logic [31:0]         conv_y,
    input  logic [15:0]         conv_c
);

    localparam int CW = $clog2(CONV_LAT + 1);
    localparam logic [DIM_BITS:0] MAXW = (DIM_BITS + 1)'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, OUT} state_t;

    state_t              state_q;
    logic [DIM_BITS-1:0] w_q, h_q;
    logic [DIM_BITS-1:0] row_q, col_q;
    logic [DIM_BITS-1:0] row_d, col_d;
    logic [23:0]         hold_q;
    logic                last_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q, done_q, err_q;
    logic                pix_ready_q, blk_valid_q;
    logic [31:0]         blk_y_q;
    logic [15:0]         blk_c_q;
    logic [23:0]         ul_q, ur_q, dl_q, dr_q;

    logic [23:0]         line_buf [MAX_WIDTH];

    logic                hs;
    logic                col_end, row_end;
    logic                cfg_ok;
    logic [DIM_BITS-1:0] col_m1;

    assign hs      = (state_q == RUN) && pix_ready_q && bus.pix_valid;
    assign col_end = (col_q == w_q - 1'b1);
    assign row_end = (row_q == h_q - 1'b1);
    assign col_m1  = col_q - 1'b1;

    assign cfg_ok = !width[0] && (width != '0) && ({1'b0, width} <= MAXW)
                  && !height[0] && (height != '0);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (hs) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Even-row storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (hs && !row_q[0]) begin
            line_buf[col_q] <= bus.pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            hold_q      <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pix_ready_q <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_y_q     <= '0;
            blk_c_q     <= '0;
            ul_q        <= '0;
            ur_q        <= '0;
            dl_q        <= '0;
            dr_q        <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w_q         <= width;
                            h_q         <= height;
                            row_q       <= '0;
                            col_q       <= '0;
                            busy_q      <= 1'b1;
                            pix_ready_q <= 1'b1;
                            state_q     <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        col_q <= col_d;
                        row_q <= row_d;
                        if (row_q[0]) begin
                            if (!col_q[0]) begin
                                hold_q <= bus.pix_data;
                            end else begin
                                // Block complete: present the 2x2 to the converter.
                                ul_q        <= line_buf[col_m1];
                                ur_q        <= line_buf[col_q];
                                dl_q        <= hold_q;
                                dr_q        <= bus.pix_data;
                                last_q      <= row_end && col_end;
                                cnt_q       <= '0;
                                pix_ready_q <= 1'b0;
                                state_q     <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    // Spends CONV_LAT+1 edges here so the converter output is settled.
                    if (cnt_q == CW'(CONV_LAT)) begin
                        blk_y_q     <= conv_y;
                        blk_c_q     <= conv_c;
                        blk_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.blk_ready) begin
                        blk_valid_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            pix_ready_q <= 1'b1;
                            state_q     <= RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign bus.pix_ready = pix_ready_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_y     = blk_y_q;
    assign bus.blk_c     = blk_c_q;
    assign conv_rgb_ul   = ul_q;
    assign conv_rgb_ur   = ur_q;
    assign conv_rgb_dl   = dl_q;
    assign conv_rgb_dr   = dr_q;

endmodule

// File: tb/tb_cc_frame_sched.sv
// Directed testbench for cc_frame_sched with a one-cycle stub converter.
// Stub: conv_y = R bytes {dr,dl,ur,ul}, conv_c = {G_ul, B_ul}.
module tb_cc_frame_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  width;
    logic [9:0]  height;
    logic        busy, done, err;
    logic [23:0] conv_rgb_ul, conv_rgb_ur, conv_rgb_dl, conv_rgb_dr;
    logic [31:0] conv_y;
    logic [15:0] conv_c;

    int checks;
    int errors;
    int done_cnt;
    logic [47:0] blk_log [$];

    cc_frame_sched_if bus ();

    cc_frame_sched #(
        .MAX_WIDTH (640),
        .DIM_BITS  (10),
        .CONV_LAT  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .width       (width),
        .height      (height),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .bus         (bus),
        .conv_rgb_ul (conv_rgb_ul),
        .conv_rgb_ur (conv_rgb_ur),
        .conv_rgb_dl (conv_rgb_dl),
        .conv_rgb_dr (conv_rgb_dr),
        .conv_y      (conv_y),
        .conv_c      (conv_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        conv_y <= {conv_rgb_dr[7:0], conv_rgb_dl[7:0],
                   conv_rgb_ur[7:0], conv_rgb_ul[7:0]};
        conv_c <= {conv_rgb_ul[15:8], conv_rgb_ul[23:16]};
    end

    always @(posedge clk) begin
        if (bus.blk_valid && bus.blk_ready) blk_log.push_back({bus.blk_c, bus.blk_y});
        if (done) done_cnt++;
    end

    task automatic do_start(input logic [9:0] w, input logic [9:0] h);
        start  = 1'b1;
        width  = w;
        height = h;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic send_pix(input logic [23:0] d);
        int t;
        t = 0;
        bus.pix_data  = d;
        bus.pix_valid = 1'b1;
        while (bus.pix_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL pix_timeout: pix_ready=%b required 1", bus.pix_ready);
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, err, bus.pix_ready, bus.blk_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {busy, done, err, bus.pix_ready, bus.blk_valid});
        end
        checks++;
        if ({bus.blk_y, bus.blk_c} !== 48'h0) begin
            errors++;
            $display("FAIL reset_blk: got %h required 0", {bus.blk_y, bus.blk_c});
        end
        checks++;
        if ({conv_rgb_ul, conv_rgb_ur, conv_rgb_dl, conv_rgb_dr} !== 96'h0) begin
            errors++;
            $display("FAIL reset_conv: got %h required 0",
                     {conv_rgb_ul, conv_rgb_ur, conv_rgb_dl, conv_rgb_dr});
        end
    endtask

    task automatic test_single();
        blk_log.delete();
        done_cnt = 0;
        bus.blk_ready = 1'b1;
        do_start(10'd2, 10'd2);
        checks++;
        if (busy !== 1'b1 || bus.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_start: busy=%b pix_ready=%b required 1 1", busy, bus.pix_ready);
        end
        send_pix(24'h201001);
        send_pix(24'h000002);
        send_pix(24'h000003);
        send_pix(24'h000004);
        checks++;
        if (conv_rgb_ul !== 24'h201001 || conv_rgb_ur !== 24'h000002 ||
            conv_rgb_dl !== 24'h000003 || conv_rgb_dr !== 24'h000004) begin
            errors++;
            $display("FAIL single_conv: got %h %h %h %h required 201001 000002 000003 000004",
                     conv_rgb_ul, conv_rgb_ur, conv_rgb_dl, conv_rgb_dr);
        end
        checks++;
        if (bus.pix_ready !== 1'b0 || bus.blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_wait0: pix_ready=%b blk_valid=%b required 0 0",
                     bus.pix_ready, bus.blk_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_wait1: blk_valid=%b required 0", bus.blk_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.blk_valid !== 1'b1 || bus.blk_y !== 32'h04030201 || bus.blk_c !== 16'h1020) begin
            errors++;
            $display("FAIL single_blk: valid=%b y=%h c=%h required 1 04030201 1020",
                     bus.blk_valid, bus.blk_y, bus.blk_c);
        end
        @(negedge clk);
        checks++;
        if (bus.blk_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: valid=%b done=%b busy=%b required 0 1 0",
                     bus.blk_valid, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bus.pix_ready !== 1'b0 || blk_log.size() != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL single_end: done=%b pix_ready=%b blocks=%0d dones=%0d required 0 0 1 1",
                     done, bus.pix_ready, blk_log.size(), done_cnt);
        end
    endtask

    task automatic test_frame4(input bit dup_start);
        logic [31:0] exp_y [4];
        int t;
        exp_y[0] = 32'h05040100;
        exp_y[1] = 32'h07060302;
        exp_y[2] = 32'h0D0C0908;
        exp_y[3] = 32'h0F0E0B0A;
        blk_log.delete();
        done_cnt = 0;
        bus.blk_ready = 1'b1;
        do_start(10'd4, 10'd4);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                send_pix({16'h0, 8'(4 * r + c)});
                if (dup_start && r == 1 && c == 0) begin
                    do_start(10'd2, 10'd2);
                    checks++;
                    if (err !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL dup_start: err=%b busy=%b required 0 1", err, busy);
                    end
                end
            end
        end
        t = 0;
        while (done_cnt == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame4_done: dones=%0d busy=%b required 1 0", done_cnt, busy);
        end
        checks++;
        if (blk_log.size() != 4) begin
            errors++;
            $display("FAIL frame4_count: blocks=%0d required 4", blk_log.size());
        end
        for (int i = 0; i < 4 && i < blk_log.size(); i++) begin
            checks++;
            if (blk_log[i] !== {16'h0, exp_y[i]}) begin
                errors++;
                $display("FAIL frame4_blk%0d: got %h required %h", i, blk_log[i], {16'h0, exp_y[i]});
            end
        end
    endtask

    task automatic test_stall();
        blk_log.delete();
        done_cnt = 0;
        bus.blk_ready = 1'b0;
        do_start(10'd2, 10'd2);
        send_pix(24'h201001);
        send_pix(24'h000002);
        send_pix(24'h000003);
        send_pix(24'h000004);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.blk_valid !== 1'b1 || bus.blk_y !== 32'h04030201) begin
            errors++;
            $display("FAIL stall_blk: valid=%b y=%h required 1 04030201", bus.blk_valid, bus.blk_y);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.blk_valid !== 1'b1 || bus.blk_y !== 32'h04030201 ||
                bus.blk_c !== 16'h1020 || bus.pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b y=%h c=%h pix_ready=%b required 1 04030201 1020 0",
                         i, bus.blk_valid, bus.blk_y, bus.blk_c, bus.pix_ready);
            end
        end
        bus.blk_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.blk_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || blk_log.size() != 1) begin
            errors++;
            $display("FAIL stall_done: valid=%b done=%b busy=%b blocks=%0d required 0 1 0 1",
                     bus.blk_valid, done, busy, blk_log.size());
        end
        @(negedge clk);
    endtask

    task automatic test_err();
        logic [19:0] cfg [4];
        cfg[0] = {10'd3, 10'd2};
        cfg[1] = {10'd0, 10'd2};
        cfg[2] = {10'd2, 10'd5};
        cfg[3] = {10'd642, 10'd2};
        for (int i = 0; i < 4; i++) begin
            do_start(cfg[i][19:10], cfg[i][9:0]);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL err_cfg%0d: err=%b busy=%b pix_ready=%b required 1 0 0",
                         i, err, busy, bus.pix_ready);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse%0d: err=%b busy=%b required 0 0", i, err, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.blk_ready = 1'b1;
        do_start(10'd4, 10'd4);
        for (int i = 0; i < 6; i++) send_pix({16'h0, 8'(i < 4 ? i : i)});
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, bus.pix_ready, bus.blk_valid, done} !== 4'b0 ||
            conv_rgb_ur !== 24'h0 || conv_rgb_dr !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b pix_ready=%b valid=%b done=%b ur=%h dr=%h required all 0",
                     busy, bus.pix_ready, bus.blk_valid, done, conv_rgb_ur, conv_rgb_dr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        blk_log.delete();
        done_cnt = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (blk_log.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: blocks=%0d dones=%0d busy=%b required 0 0 0",
                     blk_log.size(), done_cnt, busy);
        end
        test_single();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        done_cnt      = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        width         = '0;
        height        = '0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.blk_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single();
        test_frame4(1'b0);
        test_stall();
        test_err();
        test_reset_mid();
        test_frame4(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_frame_sched.md
Name: cc_frame_sched

Overview:
- Frame-level scheduler for the 2x2 colorspace converter (RGB -> YCbCr 4:2:0 with block chroma averaging).
- Accepts a raster-order RGB pixel stream and buffers one even line.
- For each 2x2 block, presents the four pixels to the converter and waits its fixed latency.
- Captures the four Y bytes plus the Cb/Cr pair and emits them as one block on a valid/ready output. Sits between the pixel DMA/input FIFO and the block output register file.

Parameters:
MAX_WIDTH, 640, maximum pixels per line; sizes the line buffer
DIM_BITS, 10, width of the width/height/column/row fields
CONV_LAT, 1, converter latency in clocks from its input sampling edge to valid output (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; latches width/height and begins a frame
width  in  DIM_BITS  pixels per line; must be even, 2..MAX_WIDTH
height  in  DIM_BITS  lines per frame; must be even, >=2
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last block handshake
err  out  1  one-cycle pulse on a rejected start
pix_valid  in  1  input pixel valid
pix_ready  out  1  input pixel ready
pix_data  in  24  RGB pixel: [7:0]=R, [15:8]=G, [23:16]=B
conv_rgb_ul, conv_rgb_ur, conv_rgb_dl, conv_rgb_dr  out  24 each  converter inputs (up-left, up-right, down-left, down-right)
conv_y  in  32  converter Y bytes: [7:0] ul, [15:8] ur, [23:16] dl, [31:24] dr
conv_c  in  16  converter chroma: [7:0] Cb, [15:8] Cr
blk_valid  out  1  output block valid
blk_ready  in  1  output block ready
blk_y  out  32  captured conv_y
blk_c  out  16  captured conv_c

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including busy, done, err, pix_ready, blk_valid, blk_y, blk_c and all conv_rgb_*. Row/col counters are 0. Line buffer contents are don't-care.
- Reset mid-frame aborts the frame: no done, partial block discarded.
- IDLE:
  - On start with valid config: latch width/height, row=col=0, busy=1, go to RUN.
  - On invalid config (width odd, 0 or >MAX_WIDTH; height odd or 0): err=1 for one cycle, stay IDLE, busy=0.
  - start while busy is ignored.
- RUN:
  - pix_ready=1.
  - Each pixel handshake (pix_valid & pix_ready) is handled by row parity:
    - Even row: write line_buf[col]=pix_data.
    - Odd row, even col: store pix_data in hold_left.
    - Odd row, odd col: block complete. At this edge (E0), register conv_rgb_ul=line_buf[col-1], conv_rgb_ur=line_buf[col], conv_rgb_dl=hold_left, conv_rgb_dr=pix_data; go to WAIT.
  - Every handshake advances col. When col==width-1, col wraps to 0 and row increments.
- WAIT:
  - pix_ready=0.
  - conv_rgb_* held stable.
  - Wait counter runs CONV_LAT+1 cycles. At edge E0+CONV_LAT+1, latch blk_y=conv_y, blk_c=conv_c, set blk_valid=1, go to OUT.
- OUT:
  - pix_ready=0.
  - blk_valid, blk_y and blk_c held stable until blk_ready.
  - On handshake, blk_valid=0 at the next edge, then:
    - If that block was the final one (row==height-1, col==width-1 at E0): done=1 for one cycle, busy=0, go to IDLE.
    - Otherwise return to RUN.
- Only one block is in flight. Block order is raster order of block top-left corners.
- conv_rgb_* retain their last values outside WAIT.
- Latency: the final pixel handshake at E0 gives blk_valid high after edge E0+CONV_LAT+1. With blk_ready=1, pix_ready returns 1 one cycle after the blk handshake.
- No arithmetic on pixel data. Counters are DIM_BITS wide and cannot overflow given the config checks.

Test Plan:
Stub converter used in all tests: registers conv_y = R bytes {dr,dl,ur,ul}, conv_c = {G_ul, B_ul}, CONV_LAT=1.
1. width=2, height=2; pixels R=1,2,3,4 (G=0x10, B=0x20 on first) -> one block: blk_y=0x04030201, blk_c=0x1020. blk_valid rises 2 cycles after the 4th handshake. done pulses one cycle after the blk handshake; busy falls.
2. width=4, height=4, R=4*row+col, blk_ready=1 -> 4 blocks in order: blk_y=0x05040100, 0x07060302, 0x0D0C0908, 0x0F0E0B0A; exactly one done.
3. Case 1 with blk_ready=0 for 5 cycles -> blk_valid/blk_y held unchanged, pix_ready=0 throughout, no extra block, normal completion after ready.
4. start with width=3, then width=0, then height=5 -> err pulse each time, busy stays 0, pix_ready stays 0.
5. rst_n low mid-frame of case 2 (after 6 pixels) -> all outputs 0 in the same cycle; after release, case 1 runs correctly.
6. Second start pulse during busy in case 2 -> ignored; output identical to case 2.
